// File: rtl/atomrv_hazard_ctrl.sv
// atomrv_hazard_ctrl: register-scoreboard hazard controller for the decode stage.
// Tracks pending register writes, stalls on RAW/WAW hazards, a full in-flight
// window or a drain request, and sequences the drain handshake for fence/ecall.
module atomrv_hazard_ctrl #(
  parameter int REG_ADRESS_WIDTH = 5,
  parameter int REGISTERS        = 32,
  parameter int MAX_INFLIGHT     = 4,
  parameter int CNT_W            = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        issue_valid_i,
  input  logic [REG_ADRESS_WIDTH-1:0] rs1_i,
  input  logic [REG_ADRESS_WIDTH-1:0] rs2_i,
  input  logic [REG_ADRESS_WIDTH-1:0] rd_i,
  input  logic                        use_rs1_i,
  input  logic                        use_rs2_i,
  input  logic                        wr_rd_i,
  input  logic                        wb_valid_i,
  input  logic [REG_ADRESS_WIDTH-1:0] wb_rd_i,
  input  logic                        drain_req_i,
  output logic                        issue_o,
  output logic                        stall_o,
  output logic                        drain_ack_o,
  output logic [CNT_W-1:0]            inflight_o,
  output logic [31:0]                 stall_cnt_o,
  output logic                        err_o
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

  logic [REGISTERS-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]     inflight_q, inflight_d;
  state_t               state_q, state_d;
  logic [31:0]          stall_cnt_q, stall_cnt_d;
  logic                 err_q, err_d;

  logic hazard;
  logic set_en, clr_en, err_en;

  // Hazard detection and the issue/stall decision; x0 is never considered pending.
  always_comb begin
    hazard = (use_rs1_i & (rs1_i != '0) & pend_q[rs1_i])
           | (use_rs2_i & (rs2_i != '0) & pend_q[rs2_i])
           | (wr_rd_i   & (rd_i  != '0) & pend_q[rd_i])
           | (inflight_q == CNT_W'(MAX_INFLIGHT))
           | drain_req_i
           | (state_q != ST_RUN);
    issue_o = issue_valid_i & ~hazard;
    stall_o = issue_valid_i & hazard;
    set_en  = issue_o & wr_rd_i & (rd_i != '0);
    clr_en  = wb_valid_i & (wb_rd_i != '0) & pend_q[wb_rd_i];
    err_en  = wb_valid_i & (wb_rd_i != '0) & ~pend_q[wb_rd_i];
  end

  // Scoreboard, counters and drain FSM next-state; a set after a clear of the
  // same register wins because it is applied last.
  always_comb begin
    pend_d = pend_q;
    if (clr_en) pend_d[wb_rd_i] = 1'b0;
    if (set_en) pend_d[rd_i] = 1'b1;

    inflight_d = inflight_q;
    case ({set_en, clr_en})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase

    stall_cnt_d = stall_cnt_q;
    if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;

    err_d = err_q | err_en;

    state_d = state_q;
    case (state_q)
      // An already-empty pipeline is acknowledged straight away: the request
      // itself blocks any new writer from issuing this cycle.
      ST_RUN:   if (drain_req_i) state_d = (inflight_q == '0) ? ST_DONE : ST_DRAIN;
      ST_DRAIN: if (!drain_req_i) state_d = ST_RUN;
                else if (inflight_q == '0) state_d = ST_DONE;
      ST_DONE:  if (!drain_req_i) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // All state registers with asynchronous clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q      <= '0;
      inflight_q  <= '0;
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      inflight_q  <= inflight_d;
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  assign drain_ack_o = (state_q == ST_DONE);
  assign inflight_o  = inflight_q;
  assign stall_cnt_o = stall_cnt_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_atomrv_hazard_ctrl.sv
// Scoreboard bench for atomrv_hazard_ctrl: the driver pushes hand-computed
// expected outputs per cycle, a monitor pops and compares at the falling edge.
module tb_atomrv_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        issue_valid_i = 1'b0;
  logic [4:0]  rs1_i = '0, rs2_i = '0, rd_i = '0, wb_rd_i = '0;
  logic        use_rs1_i = 1'b0, use_rs2_i = 1'b0, wr_rd_i = 1'b0;
  logic        wb_valid_i = 1'b0, drain_req_i = 1'b0;
  logic        issue_o, stall_o, drain_ack_o, err_o;
  logic [2:0]  inflight_o;
  logic [31:0] stall_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          id;
    logic        iss;
    logic        stl;
    logic [2:0]  inf;
    logic        ack;
    logic        err;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  atomrv_hazard_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .issue_valid_i(issue_valid_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .use_rs1_i(use_rs1_i), .use_rs2_i(use_rs2_i), .wr_rd_i(wr_rd_i),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .drain_req_i(drain_req_i),
    .issue_o(issue_o), .stall_o(stall_o), .drain_ack_o(drain_ack_o),
    .inflight_o(inflight_o), .stall_cnt_o(stall_cnt_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int id, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL c%0d %s got %0h expected %0h", id, name, got, want);
    end
  endtask

  // One cycle of stimulus: drive inputs after the rising edge, queue expectations.
  task automatic step(input int id, input logic iv, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] rd, input logic u1, input logic u2, input logic wr,
                      input logic wbv, input logic [4:0] wbrd, input logic drq,
                      input logic e_iss, input logic e_stl, input logic [2:0] e_inf,
                      input logic e_ack, input logic e_err, input logic [31:0] e_cnt);
    exp_t e;
    @(posedge clk_i);
    #1;
    issue_valid_i = iv; rs1_i = r1; rs2_i = r2; rd_i = rd;
    use_rs1_i = u1; use_rs2_i = u2; wr_rd_i = wr;
    wb_valid_i = wbv; wb_rd_i = wbrd; drain_req_i = drq;
    e.id = id; e.iss = e_iss; e.stl = e_stl; e.inf = e_inf;
    e.ack = e_ack; e.err = e_err; e.cnt = e_cnt;
    exp_q.push_back(e);
    $display("c%0d drive iv=%0b rs1=%0d rs2=%0d rd=%0d wr=%0b wb=%0b/%0d drq=%0b",
             id, iv, r1, r2, rd, wr, wbv, wbrd, drq);
  endtask

  // Monitor: compares the DUT against the oldest queued expectation.
  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("issue_o",     e.id, 32'(issue_o),     32'(e.iss));
      chk("stall_o",     e.id, 32'(stall_o),     32'(e.stl));
      chk("inflight_o",  e.id, 32'(inflight_o),  32'(e.inf));
      chk("drain_ack_o", e.id, 32'(drain_ack_o), 32'(e.ack));
      chk("err_o",       e.id, 32'(err_o),       32'(e.err));
      chk("stall_cnt_o", e.id, stall_cnt_o,      e.cnt);
    end
  end

  initial begin
    #2 rst_i = 1'b1;
    #2;
    chk("rst_inflight", 0, 32'(inflight_o), 0);
    chk("rst_ack",      0, 32'(drain_ack_o), 0);
    chk("rst_err",      0, 32'(err_o), 0);
    chk("rst_stallcnt", 0, stall_cnt_o, 0);
    repeat (2) @(posedge clk_i);
    #3 rst_i = 1'b0;

    //    id iv r1 r2 rd u1 u2 wr wbv wbrd drq  iss stl inf ack err cnt
    // RAW on x5 resolved by write-back
    step( 1, 1, 0, 0, 5, 0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 0);
    step( 2, 1, 5, 0, 0, 1, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0);
    step( 3, 1, 0, 5, 0, 0, 1, 0, 1, 5, 0,   0, 1, 1, 0, 0, 1);
    step( 4, 1, 5, 0, 0, 1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 2);
    // fill the window with rd=1..4, fifth writer waits for a retire
    step( 5, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 2);
    step( 6, 1, 0, 0, 2, 0, 0, 1, 0, 0, 0,   1, 0, 1, 0, 0, 2);
    step( 7, 1, 0, 0, 3, 0, 0, 1, 0, 0, 0,   1, 0, 2, 0, 0, 2);
    step( 8, 1, 0, 0, 4, 0, 0, 1, 0, 0, 0,   1, 0, 3, 0, 0, 2);
    step( 9, 1, 0, 0, 6, 0, 0, 1, 0, 0, 0,   0, 1, 4, 0, 0, 2);
    step(10, 1, 0, 0, 6, 0, 0, 1, 1, 2, 0,   0, 1, 4, 0, 0, 3);
    step(11, 1, 0, 0, 6, 0, 0, 1, 0, 0, 0,   1, 0, 3, 0, 0, 4);
    step(12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 4, 0, 0, 4);
    // x0 traffic is never tracked or counted
    step(13, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 4, 0, 0, 4);
    step(14, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0,   0, 0, 4, 0, 0, 4);
    step(15, 1, 0, 0, 0, 1, 0, 1, 1, 0, 0,   1, 0, 3, 0, 0, 4);
    step(16, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0,   1, 0, 3, 0, 0, 4);
    // issue and retire in the same cycle leave inflight unchanged
    step(17, 1, 0, 0, 7, 0, 0, 1, 1, 3, 0,   1, 0, 3, 0, 0, 4);
    step(18, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0,   0, 0, 3, 0, 0, 4);
    // drain with two writers outstanding (x6, x7)
    step(19, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 2, 0, 0, 4);
    step(20, 1, 0, 0, 0, 0, 0, 0, 1, 6, 1,   0, 1, 2, 0, 0, 5);
    step(21, 1, 0, 0, 0, 0, 0, 0, 1, 7, 1,   0, 1, 1, 0, 0, 6);
    step(22, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 0, 0, 0, 7);
    step(23, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 0, 1, 0, 8);
    step(24, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1, 0, 9);
    step(25, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 10);
    // write-back to a register that is not pending
    step(26, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0,   0, 0, 0, 0, 0, 10);
    step(27, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 10);
    step(28, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 10);
    // set wins over a same-cycle write-back to the just-issued rd
    step(29, 1, 0, 0, 10, 0, 0, 1, 1, 10, 0, 1, 0, 0, 0, 1, 10);
    step(30, 1, 0, 0, 10, 0, 0, 1, 0, 0, 0,  0, 1, 1, 0, 1, 10);
    step(31, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 1, 11);

    // asynchronous reset away from any clock edge
    @(posedge clk_i);
    #3 rst_i = 1'b1;
    #1;
    $display("c32 async reset asserted");
    chk("arst_issue",    32, 32'(issue_o), 0);
    chk("arst_stall",    32, 32'(stall_o), 0);
    chk("arst_inflight", 32, 32'(inflight_o), 0);
    chk("arst_ack",      32, 32'(drain_ack_o), 0);
    chk("arst_err",      32, 32'(err_o), 0);
    chk("arst_stallcnt", 32, stall_cnt_o, 0);
    #3 rst_i = 1'b0;

    // x10 no longer pending; a late write-back to it is an error
    step(33, 1, 10, 0, 0, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0);
    step(34, 0, 0, 0, 0, 0, 0, 0, 1, 10, 0,  0, 0, 0, 0, 0, 0);
    step(35, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk_i);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
